// File: rtl/stage_decode.sv
// RV32I decode stage: register file, operand forwarding/stall, branch/jump resolution, halt.
// Macro STAGE_DECODE_BYPASS_EN enables EX/MA operand forwarding; undefined stalls on any EX/MA match.
module stage_decode (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_ir,
  input  logic        if_valid,
  input  logic [4:0]  hz_ex_wb_addr,
  input  logic [31:0] hz_ex_wb_data,
  input  logic        hz_ex_wb_valid,
  input  logic [4:0]  hz_ma_wb_addr,
  input  logic [31:0] hz_ma_wb_data,
  input  logic        hz_ma_wb_valid,
  input  logic [4:0]  hz_wb_addr,
  input  logic [31:0] hz_wb_data,
  output logic        id_ready,
  output logic [31:0] id_jmp_addr,
  output logic        id_jmp_valid,
  output logic [31:0] id_ir,
  output logic [31:0] id_alu_op1,
  output logic [31:0] id_alu_op2,
  output logic [3:0]  id_alu_mode,
  output logic [1:0]  id_ma_mode,
  output logic [2:0]  id_ma_size,
  output logic [31:0] id_ma_data,
  output logic [1:0]  id_wb_src,
  output logic        id_halt
);
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regaddr_t;
  typedef logic [3:0]  alu_mode_t;
  typedef logic [1:0]  ma_mode_t;
  typedef logic [2:0]  ma_size_t;
  typedef logic [1:0]  wb_src_t;

  localparam word_t NOP    = 32'h0000_0013;
  localparam word_t EBREAK = 32'h0010_0073;

  localparam alu_mode_t ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                        ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                        ALU_OR = 4'd8, ALU_AND = 4'd9;
  localparam ma_mode_t MA_NONE = 2'd0, MA_LOAD = 2'd1, MA_STORE = 2'd2;
  localparam wb_src_t  WB_NONE = 2'd0, WB_ALU = 2'd1, WB_MEM = 2'd2;

  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                         OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                         OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011,
                         OPC_FENCE = 7'b0001111, OPC_SYSTEM = 7'b1110011;

  function automatic alu_mode_t f3_mode(input logic [2:0] f, input logic alt);
    case (f)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  word_t rf [32];
  logic  squash_q, halt_q;

  logic [6:0] opc;
  logic [2:0] f3;
  word_t      imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [1:0][4:0]  rs;
  logic [1:0][31:0] rv;
  logic [1:0]       pend;

  assign opc   = if_ir[6:0];
  assign f3    = if_ir[14:12];
  assign rs    = {regaddr_t'(if_ir[24:20]), regaddr_t'(if_ir[19:15])};
  assign imm_i = {{20{if_ir[31]}}, if_ir[31:20]};
  assign imm_s = {{20{if_ir[31]}}, if_ir[31:25], if_ir[11:7]};
  assign imm_b = {{19{if_ir[31]}}, if_ir[31], if_ir[7], if_ir[30:25], if_ir[11:8], 1'b0};
  assign imm_u = {if_ir[31:12], 12'b0};
  assign imm_j = {{11{if_ir[31]}}, if_ir[31], if_ir[19:12], if_ir[20], if_ir[30:21], 1'b0};

  // Operand fetch; pend flags a source whose producer value is not yet available.
  always_comb begin
    rv   = '0;
    pend = '0;
    for (int k = 0; k < 2; k++) begin
      if (rs[k] == 5'd0)                    rv[k] = '0;
`ifdef STAGE_DECODE_BYPASS_EN
      else if (rs[k] == hz_ex_wb_addr) begin rv[k] = hz_ex_wb_data; pend[k] = !hz_ex_wb_valid; end
      else if (rs[k] == hz_ma_wb_addr) begin rv[k] = hz_ma_wb_data; pend[k] = !hz_ma_wb_valid; end
`else
      else if (rs[k] == hz_ex_wb_addr || rs[k] == hz_ma_wb_addr) pend[k] = 1'b1;
`endif
      else if (rs[k] == hz_wb_addr)         rv[k] = hz_wb_data;
      else                                  rv[k] = rf[rs[k]];
    end
  end

`ifndef STAGE_DECODE_BYPASS_EN
  logic unused_fwd;
  assign unused_fwd = ^{hz_ex_wb_data, hz_ex_wb_valid, hz_ma_wb_data, hz_ma_wb_valid};
`endif

  word_t     d_ir, d_op1, d_op2, d_mdata, jmp_tgt;
  alu_mode_t d_mode;
  ma_mode_t  d_ma;
  ma_size_t  d_size;
  wb_src_t   d_wb;
  logic      use1, use2, is_jmp, halt_req;

  always_comb begin
    d_ir = NOP; d_op1 = '0; d_op2 = '0; d_mode = ALU_ADD; d_ma = MA_NONE;
    d_size = '0; d_mdata = '0; d_wb = WB_NONE;
    use1 = 1'b0; use2 = 1'b0; is_jmp = 1'b0; halt_req = 1'b0;
    jmp_tgt = if_pc + imm_b;
    case (opc)
      OPC_OP: begin
        use1 = 1'b1; use2 = 1'b1;
        d_ir = if_ir; d_op1 = rv[0]; d_op2 = rv[1]; d_size = f3;
        d_mode = f3_mode(f3, if_ir[30]); d_wb = WB_ALU;
      end
      OPC_OPIMM: begin
        use1 = 1'b1;
        d_ir = if_ir; d_op1 = rv[0]; d_size = f3; d_wb = WB_ALU;
        d_op2  = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, if_ir[24:20]} : imm_i;
        d_mode = f3_mode(f3, (f3 == 3'd5) && if_ir[30]);
      end
      OPC_LUI, OPC_AUIPC: begin
        d_ir = if_ir; d_op1 = (opc == OPC_AUIPC) ? if_pc : '0; d_op2 = imm_u;
        d_size = f3; d_wb = WB_ALU;
      end
      OPC_LOAD: begin
        use1 = 1'b1;
        d_ir = if_ir; d_op1 = rv[0]; d_op2 = imm_i; d_ma = MA_LOAD; d_size = f3; d_wb = WB_MEM;
      end
      OPC_STORE: begin
        use1 = 1'b1; use2 = 1'b1;
        d_ir = if_ir; d_op1 = rv[0]; d_op2 = imm_s; d_ma = MA_STORE; d_size = f3; d_mdata = rv[1];
      end
      OPC_JAL, OPC_JALR: begin
        use1 = (opc == OPC_JALR);
        is_jmp = 1'b1;
        jmp_tgt = (opc == OPC_JAL) ? if_pc + imm_j : (rv[0] + imm_i) & ~32'd1;
        d_ir = if_ir; d_op1 = if_pc; d_op2 = 32'd4; d_size = f3; d_wb = WB_ALU;
      end
      OPC_BRANCH: begin
        use1 = 1'b1; use2 = 1'b1;
        case (f3)
          3'd0:    is_jmp = (rv[0] == rv[1]);
          3'd1:    is_jmp = (rv[0] != rv[1]);
          3'd4:    is_jmp = ($signed(rv[0]) <  $signed(rv[1]));
          3'd5:    is_jmp = ($signed(rv[0]) >= $signed(rv[1]));
          3'd6:    is_jmp = (rv[0] <  rv[1]);
          3'd7:    is_jmp = (rv[0] >= rv[1]);
          default: is_jmp = 1'b0;
        endcase
      end
      OPC_FENCE:  ;
      OPC_SYSTEM: halt_req = (if_ir == EBREAK);
      default:    halt_req = 1'b1;
    endcase
  end

  logic stall, issue;
  assign stall        = if_valid && !squash_q && !halt_q && ((use1 && pend[0]) || (use2 && pend[1]));
  assign issue        = if_valid && !squash_q && !halt_q && !stall;
  assign id_ready     = reset_i || !(halt_q || stall);
  assign id_jmp_valid = !reset_i && issue && is_jmp;
  assign id_jmp_addr  = jmp_tgt;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (hz_wb_addr != 5'd0) begin
      rf[hz_wb_addr] <= hz_wb_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || !issue) begin
      id_ir <= NOP; id_alu_op1 <= '0; id_alu_op2 <= '0; id_alu_mode <= ALU_ADD;
      id_ma_mode <= MA_NONE; id_ma_size <= '0; id_ma_data <= '0; id_wb_src <= WB_NONE;
    end else begin
      id_ir <= d_ir; id_alu_op1 <= d_op1; id_alu_op2 <= d_op2; id_alu_mode <= d_mode;
      id_ma_mode <= d_ma; id_ma_size <= d_size; id_ma_data <= d_mdata; id_wb_src <= d_wb;
    end
    squash_q <= !reset_i && id_jmp_valid;
    halt_q   <= !reset_i && (halt_q || (issue && halt_req));
  end

  assign id_halt = halt_q;
endmodule

// File: tb/tb_stage_decode.sv
// Directed self-checking bench for stage_decode; expectations follow STAGE_DECODE_BYPASS_EN.
module tb_stage_decode;
  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] if_pc, if_ir;
  logic        if_valid;
  logic [4:0]  hz_ex_wb_addr, hz_ma_wb_addr, hz_wb_addr;
  logic [31:0] hz_ex_wb_data, hz_ma_wb_data, hz_wb_data;
  logic        hz_ex_wb_valid, hz_ma_wb_valid;
  logic        id_ready, id_jmp_valid, id_halt;
  logic [31:0] id_jmp_addr, id_ir, id_alu_op1, id_alu_op2, id_ma_data;
  logic [3:0]  id_alu_mode;
  logic [1:0]  id_ma_mode, id_wb_src;
  logic [2:0]  id_ma_size;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  stage_decode dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .if_pc(if_pc), .if_ir(if_ir), .if_valid(if_valid),
    .hz_ex_wb_addr(hz_ex_wb_addr), .hz_ex_wb_data(hz_ex_wb_data), .hz_ex_wb_valid(hz_ex_wb_valid),
    .hz_ma_wb_addr(hz_ma_wb_addr), .hz_ma_wb_data(hz_ma_wb_data), .hz_ma_wb_valid(hz_ma_wb_valid),
    .hz_wb_addr(hz_wb_addr), .hz_wb_data(hz_wb_data),
    .id_ready(id_ready), .id_jmp_addr(id_jmp_addr), .id_jmp_valid(id_jmp_valid),
    .id_ir(id_ir), .id_alu_op1(id_alu_op1), .id_alu_op2(id_alu_op2), .id_alu_mode(id_alu_mode),
    .id_ma_mode(id_ma_mode), .id_ma_size(id_ma_size), .id_ma_data(id_ma_data),
    .id_wb_src(id_wb_src), .id_halt(id_halt)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic [31:0] ir, input logic [31:0] op1,
                         input logic [31:0] op2, input logic [3:0] mode,
                         input logic [1:0] ma, input logic [1:0] wb);
    chk({tag, ".ir"},   id_ir,       ir);
    chk({tag, ".op1"},  id_alu_op1,  op1);
    chk({tag, ".op2"},  id_alu_op2,  op2);
    chk({tag, ".mode"}, id_alu_mode, {28'b0, mode});
    chk({tag, ".ma"},   id_ma_mode,  {30'b0, ma});
    chk({tag, ".wb"},   id_wb_src,   {30'b0, wb});
  endtask

  task automatic exp_bubble(input string tag);
    exp_out(tag, NOP, 32'd0, 32'd0, 4'd0, 2'd0, 2'd0);
  endtask

  task automatic present(input logic v, input logic [31:0] pc, input logic [31:0] ir);
    @(negedge clk_i);
    if_valid = v; if_pc = pc; if_ir = ir;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk_i);
    if_valid = 1'b0; hz_wb_addr = a; hz_wb_data = d;
    tick();
    hz_wb_addr = 5'd0;
  endtask

  initial begin
    reset_i = 1'b1; if_valid = 1'b1; if_pc = 32'h0; if_ir = 32'h008000EF;
    hz_ex_wb_addr = '0; hz_ex_wb_data = '0; hz_ex_wb_valid = 1'b0;
    hz_ma_wb_addr = '0; hz_ma_wb_data = '0; hz_ma_wb_valid = 1'b0;
    hz_wb_addr = '0; hz_wb_data = '0;
    #2;
    chk("rst.ready", id_ready, 1);
    chk("rst.jmp", id_jmp_valid, 0);
    tick();
    exp_bubble("rst");
    chk("rst.halt", id_halt, 0);
    @(negedge clk_i);
    reset_i = 1'b0; if_valid = 1'b0;

    wb_write(5'd1, 32'd5);
    wb_write(5'd13, 32'hFFFF_FFFF);
    wb_write(5'd5, 32'h203);

    // ADDI x2,x1,3
    present(1, 32'h10, 32'h00308113);
    chk("addi.ready", id_ready, 1);
    tick();
    exp_out("addi", 32'h00308113, 32'd5, 32'd3, 4'd0, 2'd0, 2'd1);

    // ADD x7,x6,x1 with x6 written the same cycle
    hz_wb_addr = 5'd6; hz_wb_data = 32'h66;
    present(1, 32'h14, 32'h001303B3);
    tick();
    hz_wb_addr = 5'd0;
    exp_out("wt", 32'h001303B3, 32'h66, 32'd5, 4'd0, 2'd0, 2'd1);

    // ADD x3,x1,x1 with EX and MA both holding x1
    hz_ex_wb_addr = 5'd1; hz_ex_wb_data = 32'd7; hz_ex_wb_valid = 1'b1;
    hz_ma_wb_addr = 5'd1; hz_ma_wb_data = 32'd9; hz_ma_wb_valid = 1'b1;
    present(1, 32'h18, 32'h001081B3);
`ifdef STAGE_DECODE_BYPASS_EN
    chk("fwd_ex.ready", id_ready, 1);
    tick();
    exp_out("fwd_ex", 32'h001081B3, 32'd7, 32'd7, 4'd0, 2'd0, 2'd1);
`else
    chk("fwd_ex.ready", id_ready, 0);
    tick();
    exp_bubble("fwd_ex");
`endif
    hz_ex_wb_addr = 5'd0;
    present(1, 32'h18, 32'h001081B3);
`ifdef STAGE_DECODE_BYPASS_EN
    chk("fwd_ma.ready", id_ready, 1);
    tick();
    exp_out("fwd_ma", 32'h001081B3, 32'd9, 32'd9, 4'd0, 2'd0, 2'd1);
`else
    chk("fwd_ma.ready", id_ready, 0);
    tick();
    exp_bubble("fwd_ma");
`endif
    hz_ma_wb_addr = 5'd0;
    present(1, 32'h18, 32'h001081B3);
    chk("fwd_rf.ready", id_ready, 1);
    tick();
    exp_out("fwd_rf", 32'h001081B3, 32'd5, 32'd5, 4'd0, 2'd0, 2'd1);

    // ADD x4,x2,x0 against a pending EX write of x2
    hz_ex_wb_addr = 5'd2; hz_ex_wb_data = 32'd0; hz_ex_wb_valid = 1'b0;
    present(1, 32'h1C, 32'h00010233);
    chk("stall.ready", id_ready, 0);
    chk("stall.jmp", id_jmp_valid, 0);
    tick();
    exp_bubble("stall");
    hz_ex_wb_valid = 1'b1; hz_ex_wb_data = 32'd4;
    present(1, 32'h1C, 32'h00010233);
`ifdef STAGE_DECODE_BYPASS_EN
    chk("unstall.ready", id_ready, 1);
    tick();
    exp_out("unstall", 32'h00010233, 32'd4, 32'd0, 4'd0, 2'd0, 2'd1);
`else
    chk("unstall.ready", id_ready, 0);
    tick();
    exp_bubble("unstall");
`endif
    // x0 source must not match an EX entry addressed to x0
    hz_ex_wb_addr = 5'd0; hz_ex_wb_valid = 1'b0; hz_ex_wb_data = 32'hDEAD;
    hz_wb_addr = 5'd2; hz_wb_data = 32'd4;
    present(1, 32'h1C, 32'h00010233);
    chk("x0.ready", id_ready, 1);
    tick();
    hz_wb_addr = 5'd0;
    exp_out("x0", 32'h00010233, 32'd4, 32'd0, 4'd0, 2'd0, 2'd1);

    // SW x2,12(x1)
    present(1, 32'h20, 32'h0020A623);
    tick();
    exp_out("sw", 32'h0020A623, 32'd5, 32'd12, 4'd0, 2'd2, 2'd0);
    chk("sw.size", id_ma_size, 2);
    chk("sw.data", id_ma_data, 4);
    // LW x8,-4(x1)
    present(1, 32'h24, 32'hFFC0A403);
    tick();
    exp_out("lw", 32'hFFC0A403, 32'd5, 32'hFFFF_FFFC, 4'd0, 2'd1, 2'd2);
    chk("lw.size", id_ma_size, 2);
    // SRAI x9,x1,3
    present(1, 32'h28, 32'h4030D493);
    tick();
    exp_out("srai", 32'h4030D493, 32'd5, 32'd3, 4'd7, 2'd0, 2'd1);
    // SUB x10,x1,x2
    present(1, 32'h2C, 32'h40208533);
    tick();
    exp_out("sub", 32'h40208533, 32'd5, 32'd4, 4'd1, 2'd0, 2'd1);
    // LUI x11,0x12345
    present(1, 32'h30, 32'h123455B7);
    tick();
    exp_out("lui", 32'h123455B7, 32'd0, 32'h12345000, 4'd0, 2'd0, 2'd1);
    // AUIPC x12,1
    present(1, 32'h40, 32'h00001617);
    tick();
    exp_out("auipc", 32'h00001617, 32'h40, 32'h1000, 4'd0, 2'd0, 2'd1);

    // BLTU x13,x1 (not taken), BLT x13,x1,+16 (taken)
    present(1, 32'h80, 32'h0016E863);
    chk("bltu.jmp", id_jmp_valid, 0);
    tick();
    exp_bubble("bltu");
    present(1, 32'h84, 32'h0016C863);
    chk("blt.jmp", id_jmp_valid, 1);
    chk("blt.addr", id_jmp_addr, 32'h94);
    tick();
    exp_bubble("blt");
    present(0, 32'h88, NOP);
    tick();

    // BEQ x2,x2 held off by a pending x2
    hz_ex_wb_addr = 5'd2; hz_ex_wb_valid = 1'b0;
    present(1, 32'h100, 32'h00210863);
    chk("bstall.ready", id_ready, 0);
    chk("bstall.jmp", id_jmp_valid, 0);
    tick();
    exp_bubble("bstall");
    hz_ex_wb_addr = 5'd0;

    // BEQ x0,x0,+16 then a squashed JAL
    present(1, 32'h100, 32'h00000863);
    chk("beq.jmp", id_jmp_valid, 1);
    chk("beq.addr", id_jmp_addr, 32'h110);
    chk("beq.ready", id_ready, 1);
    tick();
    exp_bubble("beq");
    present(1, 32'h104, 32'h008000EF);
    chk("squash.jmp", id_jmp_valid, 0);
    chk("squash.ready", id_ready, 1);
    tick();
    exp_bubble("squash");
    present(1, 32'h200, 32'h008000EF);
    chk("jal.jmp", id_jmp_valid, 1);
    chk("jal.addr", id_jmp_addr, 32'h208);
    tick();
    exp_out("jal", 32'h008000EF, 32'h200, 32'd4, 4'd0, 2'd0, 2'd1);
    present(0, 32'h204, NOP);
    tick();

    // JALR x1,8(x5) with x5=0x203
    present(1, 32'h300, 32'h008280E7);
    chk("jalr.jmp", id_jmp_valid, 1);
    chk("jalr.addr", id_jmp_addr, 32'h20A);
    tick();
    exp_out("jalr", 32'h008280E7, 32'h300, 32'd4, 4'd0, 2'd0, 2'd1);
    present(0, 32'h304, NOP);
    tick();

    present(1, 32'h310, 32'h0000000F);
    tick();
    exp_bubble("fence");
    present(1, 32'h314, 32'h00000073);
    tick();
    exp_bubble("ecall");
    chk("ecall.halt", id_halt, 0);

    // EBREAK halts until reset
    present(1, 32'h318, 32'h00100073);
    chk("ebreak.ready", id_ready, 1);
    tick();
    exp_bubble("ebreak");
    chk("ebreak.halt", id_halt, 1);
    present(1, 32'h31C, 32'h00308113);
    chk("halted.ready", id_ready, 0);
    tick();
    exp_bubble("halted");
    present(1, 32'h320, 32'h008000EF);
    chk("halted.jmp", id_jmp_valid, 0);
    tick();
    tick();
    chk("halted.halt", id_halt, 1);
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    chk("hrst.ready", id_ready, 1);
    chk("hrst.jmp", id_jmp_valid, 0);
    tick();
    chk("hrst.halt", id_halt, 0);
    @(negedge clk_i);
    reset_i = 1'b0; if_valid = 1'b0;

    // reset while stalled drops the stalled instruction
    hz_ex_wb_addr = 5'd2; hz_ex_wb_valid = 1'b0;
    present(1, 32'h1C, 32'h00010233);
    chk("rstall.ready", id_ready, 0);
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    chk("rstall.rst_ready", id_ready, 1);
    tick();
    exp_bubble("rstall");
    @(negedge clk_i);
    reset_i = 1'b0; hz_ex_wb_addr = 5'd0;
    present(0, 32'h0, NOP);
    tick();
    exp_bubble("rstall.after");
    // x1 cleared by reset
    present(1, 32'h10, 32'h00308113);
    tick();
    exp_out("rf_rst", 32'h00308113, 32'd0, 32'd3, 4'd0, 2'd0, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/stage_decode.md
STAGE_DECODE -- requirements
Module: stage_decode

Interface
REQ-001 SHALL have no parameters; types: word_t = 32 bits, regaddr_t = 5 bits, alu_mode_t = 4 bits, ma_mode_t = 2 bits, ma_size_t = 3 bits, wb_src_t = 2 bits.
REQ-002 clk_i  in  1  single clock; all state on rising edge.
REQ-003 reset_i  in  1  reset, synchronous and active-high.
REQ-004 if_pc  in  32  PC of the fetched instruction.
REQ-005 if_ir  in  32  fetched instruction.
REQ-006 if_valid  in  1  if_pc/if_ir valid.
REQ-007 hz_ex_wb_addr / hz_ex_wb_data / hz_ex_wb_valid  in  5/32/1  EX-stage pending write-back (valid=0: data not yet known).
REQ-008 hz_ma_wb_addr / hz_ma_wb_data / hz_ma_wb_valid  in  5/32/1  MA-stage pending write-back.
REQ-009 hz_wb_addr / hz_wb_data  in  5/32  WB-stage register-file write; addr 0 = no write.
REQ-010 id_ready  out  1  decode accepts if_* this cycle.
REQ-011 id_jmp_addr  out  32  redirect target.
REQ-012 id_jmp_valid  out  1  redirect fetch this cycle.
REQ-013 id_ir  out  32  instruction passed to EX.
REQ-014 id_alu_op1 / id_alu_op2  out  32/32  ALU operands.
REQ-015 id_alu_mode  out  4  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9.
REQ-016 id_ma_mode  out  2  NONE=0 LOAD=1 STORE=2.
REQ-017 id_ma_size  out  3  = funct3 (B=0 H=1 W=2 BU=4 HU=5).
REQ-018 id_ma_data  out  32  store data (forwarded rs2).
REQ-019 id_wb_src  out  2  NONE=0 ALU=1 MEM=2.
REQ-020 id_halt  out  1  sticky halt.

Function
REQ-021 SHALL contain a 32x32 register file, x0 reads 0; write hz_wb_data to hz_wb_addr (addr!=0) each edge.
REQ-022 Operand priority: EX, then MA, then WB (same-cycle write-through), then register file; source x0 never forwarded.
REQ-023 Stall: rs1/rs2 (used by the opcode, !=0) matches hz_ex or hz_ma addr with valid=0 -> id_ready=0, jmp suppressed, bubble issued.
REQ-024 EX-side outputs registered: one-cycle latency from if_* to id_*.
REQ-025 Bubble = id_ir 32'h00000013, ops 0, ADD, ma NONE, wb NONE; issued on !if_valid, stall, squash, halt.
REQ-026 OP/OP-IMM: op1=rs1, op2=rs2 or I-imm, mode from funct3/funct7[5] (SUB/SRA), wb ALU; SLLI/SRLI/SRAI op2=shamt.
REQ-027 LUI op1=0, AUIPC op1=pc; op2=U-imm, ADD, wb ALU.
REQ-028 LOAD: op1=rs1, op2=I-imm, ADD, ma LOAD, wb MEM; STORE: op2=S-imm, ma STORE, ma_data=rs2, wb NONE.
REQ-029 JAL/JALR: op1=pc, op2=4, ADD, wb ALU; id_jmp_addr = pc+J-imm / (rs1+I-imm)&~1, id_jmp_valid=1.
REQ-030 BRANCH (BEQ/BNE/BLT/BGE/BLTU/BGEU) compare forwarded operands; taken -> id_jmp_addr = pc+B-imm, id_jmp_valid=1; bubble downstream.
REQ-031 id_jmp_* combinational, same cycle as accepted if_*; instruction presented the following cycle is squashed.
REQ-032 EBREAK or unrecognised opcode -> bubble, id_halt=1 from next cycle until reset; id_ready=0 while halted.
REQ-033 FENCE/ECALL decode as bubble (NOP).

Reset
REQ-034 While reset_i high at an edge: registers x1-x31 = 0, id_* = bubble, id_halt=0, squash cleared; id_jmp_valid=0 and id_ready=1 combinationally during reset; reset mid-stall discards the stalled instruction.

Configuration
REQ-035 Macro STAGE_DECODE_BYPASS_EN: defined -> REQ-022/023 as stated; undefined -> no EX/MA forwarding, stall whenever a used source matches nonzero hz_ex_wb_addr or hz_ma_wb_addr regardless of valid (WB write-through retained).

Verification
REQ-036 x1 written 5 via WB; ADDI x2,x1,3 -> next cycle op1=5, op2=3, ADD, wb ALU.
REQ-037 hz_ex addr=1 data=7 valid=1, hz_ma addr=1 data=9 -> ADD x3,x1,x1 op1=op2=7.
REQ-038 hz_ex addr=2 valid=0, ADD x4,x2,x0 -> id_ready=0, bubble out; valid=1 data=4 -> op1=4.
REQ-039 pc=0x100, BEQ x0,x0,+16 -> same cycle id_jmp_valid=1, id_jmp_addr=0x110; next instruction squashed.
REQ-040 JALR x1,8(x5) with x5=0x203 -> id_jmp_addr=0x20A, op1=pc, op2=4; EBREAK -> id_halt=1 held until reset_i.
